item_ram_arbiter: RTL
=====================

# item_ram_arbiter

Arbiter and sequencer for the single-port 16×32 item RAM that holds stone/gold/diamond records. It sits between the RAM macro and three requesters: the stone renderer and the rope controllers of player 0 and player 1 in two-player mode. It serialises accesses, returns read data to the correct requester, and gives a rope an uninterrupted read-modify-write window while it grabs or moves an item.

## Interface
Parameters:
- ADDR_W, 4, item index width.
- DATA_W, 32, item record width.
- RAM_LAT, 1, cycles from a registered RAM address to valid ram_q (1..3).

Ports:
- clock  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- draw_lock  in  1  renderer frame window; rope requests are not granted while high.
- d_req  in  1  renderer read request; held until d_gnt.
- d_addr  in  ADDR_W  renderer read index.
- d_gnt  out  1  one-cycle grant pulse to the renderer.
- d_rvalid  out  1  one-cycle pulse; rdata is valid for the renderer.
- pN_req, N=0,1  in  1  rope request; held until pN_gnt.
- pN_we  in  1  1 = write, 0 = read.
- pN_lock  in  1  hold ownership across consecutive accesses (RMW).
- pN_addr  in  ADDR_W  item index.
- pN_wdata  in  DATA_W  write data.
- pN_gnt  out  1  one-cycle grant pulse.
- pN_rvalid  out  1  one-cycle read-data-valid pulse.
- rdata  out  DATA_W  shared read data bus, qualified by the *_rvalid pulses.
- ram_address  out  ADDR_W  registered RAM address.
- ram_data  out  DATA_W  registered RAM write data.
- ram_wren  out  1  registered RAM write enable.
- ram_q  in  DATA_W  RAM read data.

## Operation
- One access per cycle at most. Arbitration is combinational on the current request inputs. Grant, RAM address, data and wren are all registered on the same edge.
- Priority:
  - The renderer is always first. It is read-only, with no write port.
  - Between the ropes, the owner of an active lock goes first. Otherwise round-robin: pointer rr, reset 0, moves to the other rope after each rope grant.
- Lock state machine, states IDLE / OWN0 / OWN1:
  - IDLE→OWNn when pN is granted with pN_lock=1.
  - OWNn→IDLE on the first cycle pN_lock=0. Deassertion takes effect that same cycle, so the other rope may be granted on that cycle.
  - In OWNn the other rope is never granted. The renderer may still interleave (reads only).
- Rope requests with draw_lock=1 wait. A lock already held persists through draw_lock, but that rope's accesses also wait.
- Read return: a RAM_LAT+1-deep shift register carries {valid, owner[1:0]} for each granted read. On exit, the owner's rvalid pulses and rdata = ram_q. Writes produce no rvalid.
- Requester contract:
  - Drop req, or present the next access, in the cycle after gnt.
  - Do not change addr/we/wdata while req is high and not granted.
- Simultaneous events:
  - All three requesting: d_gnt.
  - p0 and p1 requesting, no lock, rr=1: p1 granted; rr→0.
  - Write then read of the same address by the same rope on back-to-back grants: the read returns the new data (RAM read-after-write is new-data; the arbiter adds no bypass).
- Reset mid-operation:
  - In-flight reads are discarded. No rvalid is emitted after reset.
  - The lock state returns to IDLE.

## Timing
- Request seen at edge k with a free arbiter → gnt high and ram_* driven in cycle k+1 → rvalid and rdata in cycle k+1+RAM_LAT. For RAM_LAT=1 that is 2 cycles from req to data.
- Back-to-back grants to one requester are allowed every cycle. Throughput is 1 access/cycle.
- Reset values: all gnt/rvalid 0, rdata 0, ram_address 0, ram_data 0, ram_wren 0, rr 0, lock state IDLE, shift register cleared.
- ram_wren is high for exactly one cycle per granted write. It is never high in a cycle with no grant.

## Structure
- The shared package item_pkg holds:
  - ADDR_W and DATA_W.
  - Requester ID constants REQ_DRAW=0, REQ_P0=1, REQ_P1=2.
  - Item record field positions: x[31:23], y[18:11], type[3:2], visible bit 1, moving bit 0.
- Sub-module rd_return_pipe: the parameterised {valid, owner} delay line that generates the per-requester rvalid and drives rdata.

## Test plan
- Reset, then d_req with addr=3: d_gnt at cycle 1, ram_address=3, d_rvalid at cycle 2 with rdata = RAM[3]. No other output toggles.
- d_req, p0_req and p1_req held together for 6 cycles: grant order is D, then P0, P1, P0… once d_req drops. Each rvalid goes to the matching owner only.
- p0 RMW with lock on addr 5 (read, then write 0x1234_5678), while p1 requests continuously: p1 is not granted until p0_lock falls. A following read of 5 returns 0x1234_5678.
- draw_lock=1 with p1_req pending for 10 cycles: no p1_gnt and no ram_wren. p1_gnt arrives in the first cycle after draw_lock falls.
- Assert resetn=0 on the cycle after a p0 read grant: no p0_rvalid appears, and all outputs are 0 on the following cycle.
- RAM_LAT=3 build, back-to-back reads by D, P0, P1 to addresses 1, 2, 3: rvalids appear in that order on consecutive cycles, 4 cycles after each request, with the correct data.

Source files
------------

// File: rtl/item_pkg.sv
// Shared definitions for the item RAM: geometry, requester identifiers,
// item record field positions and the lock/return-path types.
package item_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    // Requester identifiers, also used as the owner tag on the read return path
    localparam logic [1:0] REQ_DRAW = 2'd0;
    localparam logic [1:0] REQ_P0   = 2'd1;
    localparam logic [1:0] REQ_P1   = 2'd2;

    // Item record layout
    localparam int ITEM_X_MSB       = 31;
    localparam int ITEM_X_LSB       = 23;
    localparam int ITEM_Y_MSB       = 18;
    localparam int ITEM_Y_LSB       = 11;
    localparam int ITEM_TYPE_MSB    = 3;
    localparam int ITEM_TYPE_LSB    = 2;
    localparam int ITEM_VISIBLE_BIT = 1;
    localparam int ITEM_MOVING_BIT  = 0;

    // Rope ownership of the RAM for read-modify-write sequences
    typedef enum logic [1:0] {
        LOCK_IDLE = 2'd0,
        LOCK_OWN0 = 2'd1,
        LOCK_OWN1 = 2'd2
    } lock_state_t;

    // One entry of the read-return delay line
    typedef struct packed {
        logic       valid;
        logic [1:0] owner;
    } rd_tag_t;

    // Extract the item type field (stone/gold/diamond) from a record
    function automatic logic [1:0] item_type(input logic [DATA_W-1:0] rec);
        return rec[ITEM_TYPE_MSB:ITEM_TYPE_LSB];
    endfunction

endpackage

// File: rtl/rd_return_pipe.sv
// Delay line that follows each granted read through the RAM latency and,
// on exit, pulses the owner's rvalid while presenting ram_q on rdata.
module rd_return_pipe #(
    parameter int RAM_LAT = 1,
    parameter int DATA_W  = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_push,
    input  logic [1:0]        i_owner,
    input  logic [DATA_W-1:0] i_ram_q,
    output logic              o_d_rvalid,
    output logic              o_p0_rvalid,
    output logic              o_p1_rvalid,
    output logic [DATA_W-1:0] o_rdata
);
    import item_pkg::*;

    rd_tag_t [RAM_LAT:0] r_tag;
    rd_tag_t             w_in;
    rd_tag_t             w_exit;

    // Pack the incoming tag for the head of the delay line
    always_comb begin
        w_in       = '0;
        w_in.valid = i_push;
        w_in.owner = i_owner;
    end

    // Shift tags one stage per cycle; reset discards reads in flight
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_tag <= '0;
        end else begin
            r_tag <= {r_tag[RAM_LAT-1:0], w_in};
        end
    end

    // Decode the exiting tag into per-requester pulses and gate the data bus
    always_comb begin
        w_exit      = r_tag[RAM_LAT];
        o_d_rvalid  = 1'b0;
        o_p0_rvalid = 1'b0;
        o_p1_rvalid = 1'b0;
        o_rdata     = '0;
        if (w_exit.valid) begin
            o_rdata = i_ram_q;
            case (w_exit.owner)
                REQ_DRAW: o_d_rvalid  = 1'b1;
                REQ_P0:   o_p0_rvalid = 1'b1;
                REQ_P1:   o_p1_rvalid = 1'b1;
                default:  o_d_rvalid  = 1'b0;
            endcase
        end else begin
            o_rdata = '0;
        end
    end

endmodule

// File: rtl/item_ram_arbiter.sv
// Arbiter for the single-port item RAM shared by the renderer and two rope
// controllers. Renderer first, then the lock owner, then round-robin.
module item_ram_arbiter #(
    parameter int ADDR_W  = item_pkg::ADDR_W,
    parameter int DATA_W  = item_pkg::DATA_W,
    parameter int RAM_LAT = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              draw_lock,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    import item_pkg::*;

    lock_state_t       r_lock_st;
    lock_state_t       w_lock_eff;
    lock_state_t       w_lock_nxt;
    logic              r_rr;
    logic              w_rr_nxt;
    logic              w_gnt_d;
    logic              w_gnt_p0;
    logic              w_gnt_p1;
    logic              w_any_gnt;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [1:0]        w_sel_owner;
    logic              w_rd_push;
    logic              r_d_gnt;
    logic              r_p0_gnt;
    logic              r_p1_gnt;
    logic [ADDR_W-1:0] r_ram_address;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_wren;

    // Lock state and round-robin pointer registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_lock_st <= LOCK_IDLE;
            r_rr      <= 1'b0;
        end else begin
            r_lock_st <= w_lock_nxt;
            r_rr      <= w_rr_nxt;
        end
    end

    // Grant decision; a dropped lock releases ownership in the same cycle
    always_comb begin
        w_gnt_d  = 1'b0;
        w_gnt_p0 = 1'b0;
        w_gnt_p1 = 1'b0;
        case (r_lock_st)
            LOCK_OWN0: w_lock_eff = p0_lock ? LOCK_OWN0 : LOCK_IDLE;
            LOCK_OWN1: w_lock_eff = p1_lock ? LOCK_OWN1 : LOCK_IDLE;
            default:   w_lock_eff = LOCK_IDLE;
        endcase
        if (d_req) begin
            w_gnt_d = 1'b1;
        end else if (draw_lock) begin
            w_gnt_d = 1'b0;
        end else begin
            case (w_lock_eff)
                LOCK_OWN0: w_gnt_p0 = p0_req;
                LOCK_OWN1: w_gnt_p1 = p1_req;
                default: begin
                    if (p0_req && p1_req) begin
                        w_gnt_p0 = ~r_rr;
                        w_gnt_p1 = r_rr;
                    end else begin
                        w_gnt_p0 = p0_req;
                        w_gnt_p1 = p1_req;
                    end
                end
            endcase
        end
        if (w_lock_eff != LOCK_IDLE) begin
            w_lock_nxt = w_lock_eff;
        end else if (w_gnt_p0 && p0_lock) begin
            w_lock_nxt = LOCK_OWN0;
        end else if (w_gnt_p1 && p1_lock) begin
            w_lock_nxt = LOCK_OWN1;
        end else begin
            w_lock_nxt = LOCK_IDLE;
        end
        if (w_gnt_p0) begin
            w_rr_nxt = 1'b1;
        end else if (w_gnt_p1) begin
            w_rr_nxt = 1'b0;
        end else begin
            w_rr_nxt = r_rr;
        end
    end

    // Select the winning requester's access
    always_comb begin
        w_sel_addr  = d_addr;
        w_sel_we    = 1'b0;
        w_sel_data  = '0;
        w_sel_owner = REQ_DRAW;
        if (w_gnt_p0) begin
            w_sel_addr  = p0_addr;
            w_sel_we    = p0_we;
            w_sel_data  = p0_wdata;
            w_sel_owner = REQ_P0;
        end else if (w_gnt_p1) begin
            w_sel_addr  = p1_addr;
            w_sel_we    = p1_we;
            w_sel_data  = p1_wdata;
            w_sel_owner = REQ_P1;
        end else begin
            w_sel_addr  = d_addr;
            w_sel_owner = REQ_DRAW;
        end
        w_any_gnt = w_gnt_d | w_gnt_p0 | w_gnt_p1;
        w_rd_push = w_any_gnt & ~w_sel_we;
    end

    // Grants and RAM controls all launch on the same edge
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_d_gnt       <= 1'b0;
            r_p0_gnt      <= 1'b0;
            r_p1_gnt      <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wren    <= 1'b0;
        end else begin
            r_d_gnt    <= w_gnt_d;
            r_p0_gnt   <= w_gnt_p0;
            r_p1_gnt   <= w_gnt_p1;
            r_ram_wren <= w_any_gnt & w_sel_we;
            if (w_any_gnt) begin
                r_ram_address <= w_sel_addr;
            end
            if (w_any_gnt && w_sel_we) begin
                r_ram_data <= w_sel_data;
            end
        end
    end

    assign d_gnt       = r_d_gnt;
    assign p0_gnt      = r_p0_gnt;
    assign p1_gnt      = r_p1_gnt;
    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;
    assign ram_wren    = r_ram_wren;

    rd_return_pipe #(
        .RAM_LAT (RAM_LAT),
        .DATA_W  (DATA_W)
    ) u_rd_return_pipe (
        .clock       (clock),
        .resetn      (resetn),
        .i_push      (w_rd_push),
        .i_owner     (w_sel_owner),
        .i_ram_q     (ram_q),
        .o_d_rvalid  (d_rvalid),
        .o_p0_rvalid (p0_rvalid),
        .o_p1_rvalid (p1_rvalid),
        .o_rdata     (rdata)
    );

endmodule
